// File: rtl/generic_fifo_mc_pkg.sv
// Shared definitions for the multi-channel FIFO: level encodings and the
// clog2 helper used to size the channel index.
package generic_fifo_mc_pkg;

  localparam logic [1:0] LVL_Q0 = 2'd0;
  localparam logic [1:0] LVL_Q1 = 2'd1;
  localparam logic [1:0] LVL_Q2 = 2'd2;
  localparam logic [1:0] LVL_Q3 = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/generic_fifo_mc_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register clears on reset and holds when no read is issued.
module generic_fifo_mc_ram #(
  parameter int dw = 8,
  parameter int aw = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] din,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] dout
);

  logic [dw-1:0] mem [2**aw];
  logic [dw-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // A read and a write to the same address return the old word.
  always_ff @(posedge clk) begin
    if (rst)     dout_q <= '0;
    else if (re) dout_q <= mem[raddr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/generic_fifo_mc.sv
// Multi-channel FIFO: ch independent queues in one shared RAM, each with its
// own pointers, occupancy, flags and quantised level.
module generic_fifo_mc
  import generic_fifo_mc_pkg::*;
#(
  parameter  int dw = 8,
  parameter  int aw = 4,
  parameter  int ch = 4,
  parameter  int n  = 2,
  localparam int cw = clog2(ch)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ch-1:0]         clr,
  input  logic                  we,
  input  logic [cw-1:0]         wr_ch,
  input  logic [dw-1:0]         din,
  input  logic                  re,
  input  logic [cw-1:0]         rd_ch,
  output logic [dw-1:0]         dout,
  output logic                  dout_vld,
  output logic [cw-1:0]         dout_ch,
  output logic [ch-1:0]         full,
  output logic [ch-1:0]         empty,
  output logic [ch-1:0]         full_n,
  output logic [ch-1:0]         empty_n,
  output logic [2*ch-1:0]       level,
  output logic [ch*(aw+1)-1:0]  cnt,
  output logic                  wr_err,
  output logic                  rd_err
);

  // Handshake: there is no back-pressure. dout_vld is high for exactly one
  // cycle, the cycle after a read was accepted; dout/dout_ch hold otherwise.

  localparam logic [aw:0] DEPTH_C   = (aw+1)'(1 << aw);
  localparam logic [aw:0] FULL_N_C  = (aw+1)'((1 << aw) - n);
  localparam logic [aw:0] EMPTY_N_C = (aw+1)'(n);
  localparam logic [aw:0] Q3_C      = (aw+1)'(3 * (1 << aw) / 4);

  logic [ch-1:0]          wr_acc, rd_acc, wr_sel, rd_sel;
  logic [ch-1:0][aw-1:0]  wr_addr, rd_addr;
  logic [ch-1:0][aw:0]    cnt_w;
  logic [ch-1:0][1:0]     level_w;

  for (genvar k = 0; k < ch; k++) begin : g_ch
    logic [aw:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
    logic        full_q, full_d, empty_q, empty_d;
    logic        full_n_q, full_n_d, empty_n_q, empty_n_d;
    logic [1:0]  level_q, level_d;
    logic        wr_hit, rd_hit, wr_ok, rd_ok;

    always_comb begin
      wr_hit   = we && (wr_ch == cw'(k)) && !clr[k];
      rd_hit   = re && (rd_ch == cw'(k)) && !clr[k];
      // No read bypass: an empty channel never serves a read.
      rd_ok    = rd_hit && (cnt_q != '0);
      wr_ok    = wr_hit && ((cnt_q != DEPTH_C) || rd_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr[k]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
        else if (rd_ok && !wr_ok) cnt_d = cnt_q - 1'b1;
      end
      full_d    = (cnt_d == DEPTH_C);
      empty_d   = (cnt_d == '0);
      full_n_d  = (cnt_d >= FULL_N_C);
      empty_n_d = (cnt_d <= EMPTY_N_C);
      if (cnt_d >= Q3_C) level_d = LVL_Q3;
      else begin
        case (cnt_d[aw-1:aw-2])
          2'd0:    level_d = LVL_Q0;
          2'd1:    level_d = LVL_Q1;
          default: level_d = LVL_Q2;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        cnt_q     <= '0;
        full_q    <= 1'b0;
        empty_q   <= 1'b1;
        full_n_q  <= 1'b0;
        empty_n_q <= 1'b1;
        level_q   <= LVL_Q0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        cnt_q     <= cnt_d;
        full_q    <= full_d;
        empty_q   <= empty_d;
        full_n_q  <= full_n_d;
        empty_n_q <= empty_n_d;
        level_q   <= level_d;
      end
    end

    a_cnt_ok: assert property (@(posedge clk) disable iff (rst)
      (cnt_q <= DEPTH_C) && (cnt_q == (wr_ptr_q - rd_ptr_q)));

    assign wr_acc[k]  = wr_ok;
    assign rd_acc[k]  = rd_ok;
    assign wr_sel[k]  = we && (wr_ch == cw'(k));
    assign rd_sel[k]  = re && (rd_ch == cw'(k));
    assign wr_addr[k] = wr_ptr_q[aw-1:0];
    assign rd_addr[k] = rd_ptr_q[aw-1:0];
    assign cnt_w[k]   = cnt_q;
    assign level_w[k] = level_q;
    assign full[k]    = full_q;
    assign empty[k]   = empty_q;
    assign full_n[k]  = full_n_q;
    assign empty_n[k] = empty_n_q;
  end

  assign cnt   = cnt_w;
  assign level = level_w;

  logic              ram_we, ram_re;
  logic [aw+cw-1:0]  ram_waddr, ram_raddr;
  logic              dout_vld_q, dout_vld_d, wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic [cw-1:0]     dout_ch_q, dout_ch_d;

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = '0;
    ram_raddr = '0;
    for (int k = 0; k < ch; k++) begin
      if (wr_acc[k]) begin
        ram_we    = 1'b1;
        ram_waddr = {cw'(k), wr_addr[k]};
      end
      if (rd_acc[k]) begin
        ram_re    = 1'b1;
        ram_raddr = {cw'(k), rd_addr[k]};
      end
    end
    // Requests to a channel under clear vanish silently; out-of-range channels select nothing and error.
    wr_err_d   = we && !ram_we && !(|(wr_sel & clr));
    rd_err_d   = re && !ram_re && !(|(rd_sel & clr));
    dout_vld_d = ram_re;
    dout_ch_d  = ram_re ? rd_ch : dout_ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld_q <= 1'b0;
      dout_ch_q  <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      dout_vld_q <= dout_vld_d;
      dout_ch_q  <= dout_ch_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  generic_fifo_mc_ram #(.dw(dw), .aw(aw + cw)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .din   (din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .dout  (dout)
  );

  assign dout_vld = dout_vld_q;
  assign dout_ch  = dout_ch_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_generic_fifo_mc.sv
// Bench for generic_fifo_mc: per-channel queue reference model, read-data
// scoreboard drained by an independent monitor, directed and random phases.
module tb_generic_fifo_mc;

  localparam int DW = 8, AW = 3, CH = 4, N = 2, CW = 2, DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CH-1:0]         clr;
  logic                  we, re;
  logic [CW-1:0]         wr_ch, rd_ch;
  logic [DW-1:0]         din, dout;
  logic                  dout_vld, wr_err, rd_err;
  logic [CW-1:0]         dout_ch;
  logic [CH-1:0]         full, empty, full_n, empty_n;
  logic [2*CH-1:0]       level;
  logic [CH*(AW+1)-1:0]  cnt;

  int total = 0;
  int bad   = 0;

  logic [CW+DW-1:0] exp_q[$];
  logic [DW-1:0]    mq[CH][$];

  generic_fifo_mc #(.dw(DW), .aw(AW), .ch(CH), .n(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wr_ch(wr_ch), .din(din),
    .re(re), .rd_ch(rd_ch), .dout(dout), .dout_vld(dout_vld), .dout_ch(dout_ch),
    .full(full), .empty(empty), .full_n(full_n), .empty_n(empty_n),
    .level(level), .cnt(cnt), .wr_err(wr_err), .rd_err(rd_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented read word must match the oldest expectation.
  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dout_unexpected: got ch%0d %0h expected nothing", dout_ch, dout);
      end else begin
        chk("dout", {dout_ch, dout}, exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input logic ewe, input logic ere, input logic rs);
    logic [CH*(AW+1)-1:0] ecnt;
    logic [CH-1:0]        efull, eempty, efn, een;
    logic [2*CH-1:0]      elvl;
    int s, lv;
    for (int k = 0; k < CH; k++) begin
      s = mq[k].size();
      ecnt[k*(AW+1) +: (AW+1)] = s[AW:0];
      efull[k]  = (s == DEPTH);
      eempty[k] = (s == 0);
      efn[k]    = (s >= DEPTH - N);
      een[k]    = (s <= N);
      lv = s * 4 / DEPTH;
      if (lv > 3) lv = 3;
      elvl[2*k +: 2] = lv[1:0];
    end
    chk("cnt", cnt, ecnt);
    chk("full", full, efull);
    chk("empty", empty, eempty);
    chk("full_n", full_n, efn);
    chk("empty_n", empty_n, een);
    chk("level", level, elvl);
    chk("wr_err", wr_err, ewe);
    chk("rd_err", rd_err, ere);
    if (rs) begin
      chk("rst_dout", dout, 0);
      chk("rst_dout_ch", dout_ch, 0);
      chk("rst_dout_vld", dout_vld, 0);
    end
  endtask

  // Driver: apply one cycle of inputs, update the reference model, check after the edge.
  task automatic step(input logic w, input int wc, input logic [DW-1:0] d,
                      input logic r, input int rc, input logic [CH-1:0] c, input logic rs);
    logic rd_ok, wr_ok, ewe, ere;
    logic [DW-1:0] v;
    we = w; wr_ch = CW'(wc); din = d; re = r; rd_ch = CW'(rc); clr = c; rst = rs;
    ewe = 1'b0;
    ere = 1'b0;
    if (rs) begin
      for (int k = 0; k < CH; k++) mq[k].delete();
    end else begin
      rd_ok = r && !c[rc] && (mq[rc].size() > 0);
      wr_ok = w && !c[wc] && ((mq[wc].size() < DEPTH) || (rd_ok && rc == wc));
      ewe = w && !wr_ok && !c[wc];
      ere = r && !rd_ok && !c[rc];
      if (rd_ok) begin
        v = mq[rc].pop_front();
        exp_q.push_back({CW'(rc), v});
      end
      if (wr_ok) mq[wc].push_back(d);
      for (int k = 0; k < CH; k++) if (c[k]) mq[k].delete();
    end
    @(posedge clk);
    #1;
    check_state(ewe, ere, rs);
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0, '0, 1'b0);
  endtask

  initial begin
    logic [CH-1:0] c;
    logic          rs;
    int            wp;
    rst = 1'b1; clr = '0; we = 1'b0; re = 1'b0; wr_ch = '0; rd_ch = '0; din = '0;

    step(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);
    idle();

    // Fill ch2, overflow once, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 2, DW'(8'h11 + i), 1'b0, 0, '0, 1'b0);
    step(1'b1, 2, 8'h99, 1'b0, 0, '0, 1'b0);
    idle();
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 2, '0, 1'b0);
    idle();

    // Write to full ch1 alongside a read of ch1
    for (int i = 0; i < 8; i++) step(1'b1, 1, DW'($urandom), 1'b0, 0, '0, 1'b0);
    step(1'b1, 1, 8'hAA, 1'b1, 1, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 1, '0, 1'b0);
    idle();

    // Read of empty ch0 is not bypassed by a same-cycle write
    step(1'b1, 0, 8'h5A, 1'b1, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);
    idle();

    // Interleaved ch0/ch3 traffic keeps per-channel order
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2) ? 3 : 0, DW'(i), 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 3, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);
    idle();

    // Clear of ch1 with a concurrent write, then reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1, DW'(8'h30 + i), 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2, DW'(8'h40 + i), 1'b0, 0, '0, 1'b0);
    step(1'b1, 1, 8'h77, 1'b0, 0, 4'b0010, 1'b0);
    step(1'b0, 0, '0, 1'b1, 2, '0, 1'b0);
    step(1'b1, 2, 8'h55, 1'b1, 2, '0, 1'b1);
    idle();

    // Random traffic with phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      c  = ($urandom_range(0, 24) == 0) ? CH'($urandom_range(1, 15)) : '0;
      rs = ($urandom_range(0, 299) == 0);
      wp = ((i / 100) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < wp, $urandom_range(0, CH-1), DW'($urandom),
           $urandom_range(0, 99) < (100 - wp), $urandom_range(0, CH-1), c, rs);
    end

    idle();
    idle();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
